// File: rtl/load_store_unit.sv
`default_nettype none
// =============================================================================
// load_store_unit : data-memory initiator for B/H/W loads and stores.
// Optional feature macro: MISALIGNED_SPLIT_EN (split misaligned accesses).
// Revision: 1.0
// =============================================================================
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [2:0]               req_funct3_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [31:0]              req_wdata_i,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic                     mem_re_o,
  output logic                     mem_we_o,
  output logic [3:0]               mem_be_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o
);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [2:0]               f3_q, f3_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     err_q, err_d;
  logic                     split_q, split_d;
  logic [31:0]              data0_q, data0_d;
  logic [31:0]              result_q, result_d;

  logic                     req_illegal, req_misal, req_misal_err, req_split;
  logic [1:0]               off;
  logic [3:0]               size_mask;
  logic [31:0]              lanes;
  logic [7:0]               be64;
  logic [63:0]              wd64;
  logic [ADDRESS_WIDTH-1:0] word0, word1;

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [63:0] win,
                                      input logic [1:0] sh);
    logic [31:0] w;
    w = 32'(win >> {sh, 3'b000});
    case (f3)
      3'b000:  fmt = {{24{w[7]}}, w[7:0]};
      3'b001:  fmt = {{16{w[15]}}, w[15:0]};
      3'b100:  fmt = {24'b0, w[7:0]};
      3'b101:  fmt = {16'b0, w[15:0]};
      default: fmt = w;
    endcase
  endfunction

  always_comb begin
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = req_we_i;
      default:                req_illegal = 1'b1;
    endcase
  end

  assign req_misal = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));

`ifdef MISALIGNED_SPLIT_EN
  assign req_misal_err = 1'b0;
  assign req_split     = req_misal & ~req_illegal;
`else
  assign req_misal_err = req_misal;
  assign req_split     = 1'b0;
`endif

  assign off = addr_q[1:0];

  always_comb begin
    case (f3_q[1:0])
      2'b00:   begin size_mask = 4'b0001; lanes = {4{wdata_q[7:0]}};  end
      2'b01:   begin size_mask = 4'b0011; lanes = {2{wdata_q[15:0]}}; end
      default: begin size_mask = 4'b1111; lanes = wdata_q;            end
    endcase
  end

  // Split stores view the two words as one 64-bit window starting at word0.
  assign be64  = {4'b0000, size_mask} << off;
  assign wd64  = {32'b0, lanes} << {off, 3'b000};
  assign word0 = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign word1 = word0 + ADDRESS_WIDTH'(4);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    split_d  = split_q;
    data0_d  = data0_q;
    result_d = result_q;

    req_ready_o = 1'b0;
    mem_addr_o  = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d     = req_we_i;
          f3_d     = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          err_d    = req_illegal | req_misal_err;
          split_d  = req_split;
          result_d = '0;
          state_d  = (req_illegal | req_misal_err) ? RESP : ISSUE0;
        end
      end
      ISSUE0: begin
        mem_addr_o = word0;
        if (we_q) begin
          mem_we_o    = 1'b1;
          mem_be_o    = be64[3:0];
          mem_wdata_o = split_q ? wd64[31:0] : lanes;
          state_d     = split_q ? ISSUE1 : RESP;
        end else begin
          mem_re_o = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = WAIT0;
        end
      end
      WAIT0: begin
        if (cnt_q == '0) begin
          if (split_q) begin
            data0_d = mem_rdata_i;
            state_d = ISSUE1;
          end else begin
            result_d = fmt(f3_q, {32'b0, mem_rdata_i}, off);
            state_d  = RESP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ISSUE1: begin
        mem_addr_o = word1;
        if (we_q) begin
          mem_we_o    = 1'b1;
          mem_be_o    = be64[7:4];
          mem_wdata_o = wd64[63:32];
          state_d     = RESP;
        end else begin
          mem_re_o = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = WAIT1;
        end
      end
      WAIT1: begin
        if (cnt_q == '0) begin
          result_d = fmt(f3_q, {mem_rdata_i, data0_q}, off);
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = result_q;
        rsp_err_o   = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      split_q  <= 1'b0;
      data0_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      split_q  <= split_d;
      data0_q  <= data0_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// =============================================================================
// tb_load_store_unit : vector table, reset sequence and random requests checked
// against a byte-addressed memory model. Revision: 1.0
// =============================================================================
module tb_load_store_unit;
  localparam int AW  = 9;
  localparam int LAT = 1;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready_o;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [AW-1:0] mem_addr_o;
  logic          mem_re_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  // Memory device seen by the DUT; unrequested cycles return noise.
  logic [31:0] dmem [0:127];
  logic        ld_en = 1'b0;
  logic [6:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;
  always @(posedge clk) begin
    if (ld_en) dmem[ld_idx] <= ld_val;
    else if (mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) dmem[mem_addr_o[8:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    mem_rdata_i <= mem_re_o ? dmem[mem_addr_o[8:2]] : $urandom;
  end

  // Reference view of the same memory as a plain byte array.
  logic [7:0] rmem [0:511];

  int    n_chk = 0;
  int    n_err = 0;
  string cur = "init";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h expected %h", cur, nm, act, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    ld_en = 1'b1; ld_idx = idx[6:0]; ld_val = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
    for (int b = 0; b < 4; b++) rmem[idx*4 + b] = v[8*b +: 8];
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic void classify(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                                   output logic errpath, output logic split);
    logic ill, mis;
    int   sz;
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    sz  = size_of(f3);
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    errpath = ill || (mis && !SPLIT);
    split   = !ill && mis && SPLIT;
  endfunction

  function automatic void predict(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                                  output logic eerr, output logic [31:0] erd);
    logic        sp;
    logic [31:0] v;
    classify(we, f3, addr, eerr, sp);
    erd = '0;
    v   = '0;
    if (!eerr && !we) begin
      for (int k = 0; k < size_of(f3); k++) v[8*k +: 8] = rmem[(int'(addr) + k) % 512];
      case (f3)
        3'b000:  erd = {{24{v[7]}}, v[7:0]};
        3'b001:  erd = {{16{v[15]}}, v[15:0]};
        default: erd = v;
      endcase
    end
  endfunction

  task automatic check_idle_outputs(input logic exp_ready);
    chk("ready", 32'(req_ready_o), 32'(exp_ready));
    chk("mem_re", 32'(mem_re_o), 0);
    chk("mem_we", 32'(mem_we_o), 0);
    chk("mem_addr", 32'(mem_addr_o), 0);
    chk("mem_be", 32'(mem_be_o), 0);
    chk("mem_wdata", mem_wdata_o, 0);
    chk("rsp_valid", 32'(rsp_valid_o), 0);
    chk("rsp_rdata", rsp_rdata_o, 0);
    chk("rsp_err", 32'(rsp_err_o), 0);
  endtask

  // Entered just after a rising edge with the DUT idle; returns likewise.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, input logic eerr, input logic [31:0] erd);
    logic        errpath, split;
    int          sz, o, rc, i1;
    logic [7:0]  be64;
    logic [63:0] wd64;
    logic [31:0] rep;
    logic [8:0]  w0;
    classify(we, f3, addr, errpath, split);
    sz = size_of(f3);
    o  = int'(addr[1:0]);
    if (errpath)  rc = 1;
    else if (we)  rc = split ? 3 : 2;
    else          rc = split ? 3 + 2*LAT : 2 + LAT;
    i1   = split ? (we ? 2 : 2 + LAT) : -1;
    rep  = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
    be64 = '0;
    for (int k = 0; k < sz; k++) be64[o + k] = 1'b1;
    wd64 = split ? ({32'b0, rep} << (8*o)) : {32'b0, rep};
    w0   = {addr[8:2], 2'b00};

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk("accept_ready", 32'(req_ready_o), 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = 9'($urandom); req_wdata = $urandom;

    for (int c = 1; c <= rc; c++) begin
      logic        iss0, iss1;
      logic [8:0]  ea;
      logic [3:0]  eb;
      logic [31:0] ew;
      @(negedge clk);
      iss0 = !errpath && (c == 1);
      iss1 = (c == i1);
      ea   = iss0 ? w0 : iss1 ? 9'(w0 + 9'd4) : 9'd0;
      eb   = (we && iss0) ? be64[3:0] : (we && iss1) ? be64[7:4] : 4'd0;
      ew   = (we && iss0) ? wd64[31:0] : (we && iss1) ? wd64[63:32] : 32'd0;
      chk("ready", 32'(req_ready_o), 0);
      chk("mem_re", 32'(mem_re_o), 32'((iss0 || iss1) && !we));
      chk("mem_we", 32'(mem_we_o), 32'((iss0 || iss1) && we));
      chk("mem_addr", 32'(mem_addr_o), 32'(ea));
      chk("mem_be", 32'(mem_be_o), 32'(eb));
      chk("mem_wdata", mem_wdata_o, ew);
      chk("rsp_valid", 32'(rsp_valid_o), 32'(c == rc));
      chk("rsp_err", 32'(rsp_err_o), (c == rc) ? 32'(eerr) : 32'd0);
      chk("rsp_rdata", rsp_rdata_o, (c == rc) ? erd : 32'd0);
      @(posedge clk); #1;
    end
    if (!errpath && we)
      for (int k = 0; k < sz; k++) rmem[(int'(addr) + k) % 512] = wd[8*k +: 8];
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  localparam int NT = 13;
  vec_t tbl [0:NT-1];

  initial begin
    tbl[0]  = '{1'b0, 3'b000, 9'h013, 32'h0,        1'b0, 32'hFFFF_FF88};
    tbl[1]  = '{1'b0, 3'b100, 9'h011, 32'h0,        1'b0, 32'h0000_00AA};
    tbl[2]  = '{1'b0, 3'b001, 9'h012, 32'h0,        1'b0, 32'hFFFF_8899};
    tbl[3]  = '{1'b0, 3'b101, 9'h010, 32'h0,        1'b0, 32'h0000_AABB};
`ifdef MISALIGNED_SPLIT_EN
    tbl[4]  = '{1'b0, 3'b010, 9'h011, 32'h0,        1'b0, 32'h4488_99AA};
    tbl[12] = '{1'b0, 3'b001, 9'h013, 32'h0,        1'b0, 32'h0000_4412};
`else
    tbl[4]  = '{1'b0, 3'b010, 9'h011, 32'h0,        1'b1, 32'h0};
    tbl[12] = '{1'b0, 3'b001, 9'h013, 32'h0,        1'b1, 32'h0};
`endif
    tbl[5]  = '{1'b0, 3'b011, 9'h010, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 3'b010, 9'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[8]  = '{1'b1, 3'b000, 9'h012, 32'h0000_00C3, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 3'b001, 9'h012, 32'h0000_1234, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 3'b010, 9'h010, 32'h0,        1'b0, 32'h1234_BEEF};
    tbl[11] = '{1'b1, 3'b100, 9'h010, 32'h0000_0055, 1'b1, 32'h0};

    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 128; i++) set_word(i, $urandom);
    set_word(4, 32'h8899_AABB);
    set_word(5, 32'h1122_3344);
    cur = "reset_state";
    @(negedge clk);
    check_idle_outputs(1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NT; i++) begin
      cur = $sformatf("tbl%0d", i);
      run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].rd);
    end

    // Reset while a load waits for its data.
    cur = "reset_mid";
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1 check_idle_outputs(1'b1);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    cur = "after_reset";
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle_outputs(1'b1);
    end
    @(posedge clk); #1;
    cur = "load_after_reset";
    begin
      logic        e;
      logic [31:0] r;
      predict(1'b0, 3'b010, 9'h010, e, r);
      run_req(1'b0, 3'b010, 9'h010, 32'h0, e, r);
    end

    for (int n = 0; n < 120; n++) begin
      logic [2:0]  f3_tab [0:9];
      logic        we, e;
      logic [2:0]  f3;
      logic [8:0]  a;
      logic [31:0] wd, r;
      f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                 3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
      we = 1'($urandom);
      f3 = f3_tab[$urandom_range(0, 9)];
      a  = 9'($urandom);
      wd = $urandom;
      cur = $sformatf("rnd%0d", n);
      predict(we, f3, a, e, r);
      run_req(we, f3, a, wd, e, r);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check_idle_outputs(1'b1);
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
